// File: rtl/alarm_pkg.sv
// Shared types and defaults for the multi-slot alarm bank.
//   bcd_time_t    : HH:MM as four BCD digits
//   alarm_state_t : ring/snooze/stop state machine encoding
package alarm_pkg;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } bcd_time_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam int SNOOZE_MIN_DEF   = 5;
  localparam int RING_MAX_MIN_DEF = 10;

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored BCD time, enable bit and comparator.
// Ports:
//   clk, reset_n   clock, async active-low reset
//   we             write strobe for this slot
//   new_time/new_en  values captured on we
//   current_time   running clock time
//   match          enabled and stored time equals current time
//   stored_time/stored_en  slot contents for read-back
module alarm_slot
  import alarm_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      we,
  input  bcd_time_t new_time,
  input  logic      new_en,
  input  bcd_time_t current_time,
  output logic      match,
  output bcd_time_t stored_time,
  output logic      stored_en
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stored_time <= '0;
      stored_en   <= 1'b0;
    end else if (we) begin
      stored_time <= new_time;
      stored_en   <= new_en;
    end
  end

  assign match = stored_en && (stored_time == current_time);

endmodule

// File: rtl/alarm_bank.sv
// Multi-slot alarm bank: NUM_ALARMS HH:MM alarms sharing one
// ring/snooze/stop state machine.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   load_new_a, load_idx         slot write strobe and target slot
//   new_alarm_time_*, new_alarm_en  BCD digits and enable to store
//   current_time_*               running BCD time from the time counter
//   min_tick                     one-cycle pulse per minute
//   snooze, stop_alarm           one-cycle key pulses
//   rd_idx, rd_alarm_time_*, rd_alarm_en  combinational slot read-back
//   sound_alarm, ring_idx, snoozing       registered status
//
// state  | meaning
// IDLE   | no alarm active, waiting for a rising match
// RING   | alarm sounding; ring_cnt counts minutes toward auto-timeout
// SNOOZE | alarm silenced; snz_cnt counts minutes down to re-ring
module alarm_bank
  import alarm_pkg::*;
#(
  parameter  int NUM_ALARMS   = 4,
  parameter  int SNOOZE_MIN   = SNOOZE_MIN_DEF,
  parameter  int RING_MAX_MIN = RING_MAX_MIN_DEF,
  localparam int IDX_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_new_a,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [3:0]       new_alarm_time_ms_hr,
  input  logic [3:0]       new_alarm_time_ms_min,
  input  logic [3:0]       new_alarm_time_ls_hr,
  input  logic [3:0]       new_alarm_time_ls_min,
  input  logic             new_alarm_en,
  input  logic [3:0]       current_time_ms_hr,
  input  logic [3:0]       current_time_ms_min,
  input  logic [3:0]       current_time_ls_hr,
  input  logic [3:0]       current_time_ls_min,
  input  logic             min_tick,
  input  logic             snooze,
  input  logic             stop_alarm,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [3:0]       rd_alarm_time_ms_hr,
  output logic [3:0]       rd_alarm_time_ms_min,
  output logic [3:0]       rd_alarm_time_ls_hr,
  output logic [3:0]       rd_alarm_time_ls_min,
  output logic             rd_alarm_en,
  output logic             sound_alarm,
  output logic [IDX_W-1:0] ring_idx,
  output logic             snoozing
);

  localparam int CNT_MAX = (SNOOZE_MIN > RING_MAX_MIN) ? SNOOZE_MIN : RING_MAX_MIN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  bcd_time_t               new_time, cur_time;
  bcd_time_t               slot_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0]   slot_en, match, match_q, trig;
  logic [IDX_W-1:0]        win_idx, ring_idx_nx;
  logic                    any_trig, disable_hit;
  alarm_state_t            state, state_nx;
  logic [CNT_W-1:0]        ring_cnt, ring_cnt_nx, snz_cnt, snz_cnt_nx;

  assign new_time = '{ms_hr: new_alarm_time_ms_hr, ls_hr: new_alarm_time_ls_hr,
                      ms_min: new_alarm_time_ms_min, ls_min: new_alarm_time_ls_min};
  assign cur_time = '{ms_hr: current_time_ms_hr, ls_hr: current_time_ls_hr,
                      ms_min: current_time_ms_min, ls_min: current_time_ls_min};

  // Out-of-range load_idx never equals any slot index, so it is dropped.
  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    alarm_slot u_slot (
      .clk          (clk),
      .reset_n      (reset_n),
      .we           (load_new_a && (load_idx == IDX_W'(i))),
      .new_time     (new_time),
      .new_en       (new_alarm_en),
      .current_time (cur_time),
      .match        (match[i]),
      .stored_time  (slot_time[i]),
      .stored_en    (slot_en[i])
    );
  end

  always_comb begin
    rd_alarm_time_ms_hr  = '0;
    rd_alarm_time_ls_hr  = '0;
    rd_alarm_time_ms_min = '0;
    rd_alarm_time_ls_min = '0;
    rd_alarm_en          = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_alarm_time_ms_hr  = slot_time[i].ms_hr;
        rd_alarm_time_ls_hr  = slot_time[i].ls_hr;
        rd_alarm_time_ms_min = slot_time[i].ms_min;
        rd_alarm_time_ls_min = slot_time[i].ls_min;
        rd_alarm_en          = slot_en[i];
      end
    end
  end

  // Fire only on the first cycle of a match so a held minute rings once.
  assign trig     = match & ~match_q;
  assign any_trig = |trig;

  always_comb begin
    win_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (trig[i]) win_idx = IDX_W'(i);
    end
  end

  assign disable_hit = load_new_a && !new_alarm_en && (load_idx == ring_idx);

  always_comb begin
    state_nx    = state;
    ring_idx_nx = ring_idx;
    ring_cnt_nx = ring_cnt;
    snz_cnt_nx  = snz_cnt;
    unique case (state)
      IDLE: begin
        if (any_trig) begin
          state_nx    = RING;
          ring_idx_nx = win_idx;
          ring_cnt_nx = '0;
        end
      end
      RING: begin
        if (stop_alarm) begin
          state_nx = IDLE;
        end else if (snooze) begin
          state_nx   = SNOOZE;
          snz_cnt_nx = CNT_W'(SNOOZE_MIN);
        end else if (min_tick) begin
          ring_cnt_nx = ring_cnt + CNT_W'(1);
          if (ring_cnt == CNT_W'(RING_MAX_MIN - 1)) state_nx = IDLE;
        end
      end
      SNOOZE: begin
        if (stop_alarm) begin
          state_nx = IDLE;
        end else if (min_tick) begin
          snz_cnt_nx = snz_cnt - CNT_W'(1);
          if (snz_cnt == CNT_W'(1)) begin
            state_nx    = RING;
            ring_cnt_nx = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Disabling the active slot silences it regardless of key activity.
    if (state != IDLE && disable_hit) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      match_q     <= '0;
      ring_idx    <= '0;
      ring_cnt    <= '0;
      snz_cnt     <= '0;
      sound_alarm <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      state       <= state_nx;
      match_q     <= match;
      ring_idx    <= ring_idx_nx;
      ring_cnt    <= ring_cnt_nx;
      snz_cnt     <= snz_cnt_nx;
      sound_alarm <= (state_nx == RING);
      snoozing    <= (state_nx == SNOOZE);
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed self-checking bench for alarm_bank. A second instance with
// three slots covers out-of-range slot indices.
module tb_alarm_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_new_a, load_new_a3;
  logic [1:0] load_idx, load_idx3;
  logic [3:0] n_ms_hr, n_ms_min, n_ls_hr, n_ls_min;
  logic       new_alarm_en;
  logic [3:0] c_ms_hr, c_ms_min, c_ls_hr, c_ls_min;
  logic       min_tick, snooze, stop_alarm;
  logic [1:0] rd_idx;

  logic [3:0] r_ms_hr, r_ms_min, r_ls_hr, r_ls_min;
  logic       rd_en, sound_alarm, snoozing;
  logic [1:0] ring_idx;
  logic [3:0] r3_ms_hr, r3_ms_min, r3_ls_hr, r3_ls_min;
  logic       rd_en3, sound_alarm3, snoozing3;
  logic [1:0] ring_idx3;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alarm_bank dut (
    .clk(clk), .reset_n(reset_n),
    .load_new_a(load_new_a), .load_idx(load_idx),
    .new_alarm_time_ms_hr(n_ms_hr), .new_alarm_time_ms_min(n_ms_min),
    .new_alarm_time_ls_hr(n_ls_hr), .new_alarm_time_ls_min(n_ls_min),
    .new_alarm_en(new_alarm_en),
    .current_time_ms_hr(c_ms_hr), .current_time_ms_min(c_ms_min),
    .current_time_ls_hr(c_ls_hr), .current_time_ls_min(c_ls_min),
    .min_tick(min_tick), .snooze(snooze), .stop_alarm(stop_alarm),
    .rd_idx(rd_idx),
    .rd_alarm_time_ms_hr(r_ms_hr), .rd_alarm_time_ms_min(r_ms_min),
    .rd_alarm_time_ls_hr(r_ls_hr), .rd_alarm_time_ls_min(r_ls_min),
    .rd_alarm_en(rd_en), .sound_alarm(sound_alarm),
    .ring_idx(ring_idx), .snoozing(snoozing)
  );

  alarm_bank #(.NUM_ALARMS(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .load_new_a(load_new_a3), .load_idx(load_idx3),
    .new_alarm_time_ms_hr(n_ms_hr), .new_alarm_time_ms_min(n_ms_min),
    .new_alarm_time_ls_hr(n_ls_hr), .new_alarm_time_ls_min(n_ls_min),
    .new_alarm_en(new_alarm_en),
    .current_time_ms_hr(c_ms_hr), .current_time_ms_min(c_ms_min),
    .current_time_ls_hr(c_ls_hr), .current_time_ls_min(c_ls_min),
    .min_tick(min_tick), .snooze(snooze), .stop_alarm(stop_alarm),
    .rd_idx(rd_idx),
    .rd_alarm_time_ms_hr(r3_ms_hr), .rd_alarm_time_ms_min(r3_ms_min),
    .rd_alarm_time_ls_hr(r3_ls_hr), .rd_alarm_time_ls_min(r3_ls_min),
    .rd_alarm_en(rd_en3), .sound_alarm(sound_alarm3),
    .ring_idx(ring_idx3), .snoozing(snoozing3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [7:0] hh, input logic [7:0] mm);
    {c_ms_hr, c_ls_hr}   = hh;
    {c_ms_min, c_ls_min} = mm;
  endtask

  task automatic load(input int idx, input logic [7:0] hh, input logic [7:0] mm, input logic en);
    load_idx = 2'(idx);
    {n_ms_hr, n_ls_hr}   = hh;
    {n_ms_min, n_ls_min} = mm;
    new_alarm_en = en;
    load_new_a   = 1'b1;
    tick();
    load_new_a   = 1'b0;
  endtask

  task automatic arm_and_fire(input int idx, input logic [7:0] hh, input logic [7:0] mm,
                              input logic [7:0] phh, input logic [7:0] pmm);
    set_time(phh, pmm);
    load(idx, hh, mm, 1'b1);
    set_time(hh, mm);
    tick();
  endtask

  task automatic press_stop();
    stop_alarm = 1'b1;
    tick();
    stop_alarm = 1'b0;
  endtask

  task automatic pulse_min();
    min_tick = 1'b1;
    tick();
    min_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load_new_a = 0; load_new_a3 = 0; load_idx = 0; load_idx3 = 0;
    n_ms_hr = 0; n_ms_min = 0; n_ls_hr = 0; n_ls_min = 0; new_alarm_en = 0;
    min_tick = 0; snooze = 0; stop_alarm = 0; rd_idx = 0;
    set_time(8'h00, 8'h00);
    tick(); tick();
    total++;
    if ({sound_alarm, snoozing, ring_idx} !== 4'b0) $display("FAIL reset_status got %b exp 0000", {sound_alarm, snoozing, ring_idx});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i); #1;
      total++;
      if ({r_ms_hr, r_ls_hr, r_ms_min, r_ls_min, rd_en} !== 17'h0)
        $display("FAIL reset_rd%0d got %h exp 0", i, {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min, rd_en});
      else passed++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    total++;
    if ({sound_alarm, snoozing} !== 2'b0) $display("FAIL reset_release got %b exp 00", {sound_alarm, snoozing});
    else passed++;
  endtask

  task automatic test_load_fire();
    arm_and_fire(2, 8'h07, 8'h30, 8'h07, 8'h29);
    total++;
    if (sound_alarm !== 1'b1) $display("FAIL fire_sound got %b exp 1", sound_alarm); else passed++;
    total++;
    if (ring_idx !== 2'd2) $display("FAIL fire_idx got %0d exp 2", ring_idx); else passed++;
    rd_idx = 2'd2; #1;
    total++;
    if ({r_ms_hr, r_ls_hr, r_ms_min, r_ls_min, rd_en} !== {16'h0730, 1'b1})
      $display("FAIL fire_rd got %h exp %h", {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min, rd_en}, {16'h0730, 1'b1});
    else passed++;
    press_stop();
    total++;
    if (sound_alarm !== 1'b0) $display("FAIL stop_latency got %b exp 0", sound_alarm); else passed++;
    tick(); tick(); tick();
    total++;
    if (sound_alarm !== 1'b0) $display("FAIL no_refire got %b exp 0", sound_alarm); else passed++;
  endtask

  task automatic test_priority();
    set_time(8'h05, 8'h59);
    load(1, 8'h06, 8'h00, 1'b1);
    load(3, 8'h06, 8'h00, 1'b1);
    set_time(8'h06, 8'h00);
    tick();
    total++;
    if ({sound_alarm, ring_idx} !== 3'b101) $display("FAIL prio_idx got %b exp 101", {sound_alarm, ring_idx}); else passed++;
    press_stop();
    tick(); tick();
    total++;
    if (sound_alarm !== 1'b0) $display("FAIL prio_dropped got %b exp 0", sound_alarm); else passed++;
  endtask

  task automatic test_snooze();
    arm_and_fire(0, 8'h08, 8'h00, 8'h07, 8'h59);
    total++;
    if ({sound_alarm, ring_idx} !== 3'b100) $display("FAIL snz_ring got %b exp 100", {sound_alarm, ring_idx}); else passed++;
    snooze = 1'b1; tick(); snooze = 1'b0;
    total++;
    if ({sound_alarm, snoozing} !== 2'b01) $display("FAIL snz_enter got %b exp 01", {sound_alarm, snoozing}); else passed++;
    for (int i = 0; i < 4; i++) begin
      pulse_min();
      tick();
    end
    total++;
    if ({sound_alarm, snoozing} !== 2'b01) $display("FAIL snz_hold4 got %b exp 01", {sound_alarm, snoozing}); else passed++;
    pulse_min();
    total++;
    if ({sound_alarm, snoozing, ring_idx} !== 4'b1000) $display("FAIL snz_rering got %b exp 1000", {sound_alarm, snoozing, ring_idx}); else passed++;
    press_stop();
  endtask

  task automatic test_timeout_stop();
    arm_and_fire(0, 8'h09, 8'h00, 8'h08, 8'h59);
    for (int i = 0; i < 9; i++) begin
      pulse_min();
      tick();
    end
    total++;
    if (sound_alarm !== 1'b1) $display("FAIL timeout_9 got %b exp 1", sound_alarm); else passed++;
    pulse_min();
    total++;
    if ({sound_alarm, snoozing} !== 2'b00) $display("FAIL timeout_10 got %b exp 00", {sound_alarm, snoozing}); else passed++;
    arm_and_fire(0, 8'h10, 8'h00, 8'h09, 8'h59);
    total++;
    if (sound_alarm !== 1'b1) $display("FAIL stopprio_ring got %b exp 1", sound_alarm); else passed++;
    snooze = 1'b1; stop_alarm = 1'b1;
    tick();
    snooze = 1'b0; stop_alarm = 1'b0;
    total++;
    if ({sound_alarm, snoozing} !== 2'b00) $display("FAIL stop_over_snooze got %b exp 00", {sound_alarm, snoozing}); else passed++;
  endtask

  task automatic test_edge_cases();
    set_time(8'h10, 8'h01);
    load_idx3 = 2'd3;
    {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min} = 16'h1234;
    new_alarm_en = 1'b1;
    load_new_a3 = 1'b1; tick(); load_new_a3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i); #1;
      total++;
      if ({r3_ms_hr, r3_ls_hr, r3_ms_min, r3_ls_min, rd_en3} !== 17'h0)
        $display("FAIL oob_load_rd%0d got %h exp 0", i, {r3_ms_hr, r3_ls_hr, r3_ms_min, r3_ls_min, rd_en3});
      else passed++;
    end
    load_idx3 = 2'd2;
    load_new_a3 = 1'b1; tick(); load_new_a3 = 1'b0;
    rd_idx = 2'd2; #1;
    total++;
    if ({r3_ms_hr, r3_ls_hr, r3_ms_min, r3_ls_min, rd_en3} !== {16'h1234, 1'b1})
      $display("FAIL inrange_load got %h exp %h", {r3_ms_hr, r3_ls_hr, r3_ms_min, r3_ls_min, rd_en3}, {16'h1234, 1'b1});
    else passed++;

    arm_and_fire(0, 8'h11, 8'h00, 8'h10, 8'h59);
    total++;
    if (sound_alarm !== 1'b1) $display("FAIL dis_ring got %b exp 1", sound_alarm); else passed++;
    load(0, 8'h11, 8'h00, 1'b0);
    total++;
    if ({sound_alarm, snoozing} !== 2'b00) $display("FAIL dis_idle got %b exp 00", {sound_alarm, snoozing}); else passed++;

    set_time(8'h12, 8'h59);
    load(1, 8'h13, 8'h00, 1'b0);
    set_time(8'h13, 8'h00);
    tick(); tick();
    total++;
    if (sound_alarm !== 1'b0) $display("FAIL disabled_match got %b exp 0", sound_alarm); else passed++;
  endtask

  task automatic test_reset_mid_ring();
    arm_and_fire(2, 8'h14, 8'h00, 8'h13, 8'h59);
    total++;
    if ({sound_alarm, ring_idx} !== 3'b110) $display("FAIL midring_pre got %b exp 110", {sound_alarm, ring_idx}); else passed++;
    reset_n = 1'b0; #1;
    total++;
    if ({sound_alarm, snoozing, ring_idx} !== 4'b0) $display("FAIL midring_async got %b exp 0000", {sound_alarm, snoozing, ring_idx}); else passed++;
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i); #1;
      total++;
      if ({r_ms_hr, r_ls_hr, r_ms_min, r_ls_min, rd_en} !== 17'h0)
        $display("FAIL midring_rd%0d got %h exp 0", i, {r_ms_hr, r_ls_hr, r_ms_min, r_ls_min, rd_en});
      else passed++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();
    total++;
    if ({sound_alarm, snoozing, ring_idx} !== 4'b0) $display("FAIL midring_after got %b exp 0000", {sound_alarm, snoozing, ring_idx}); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_fire();
    test_priority();
    test_snooze();
    test_timeout_stop();
    test_edge_cases();
    test_reset_mid_ring();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
